// File: rtl/avalon_st_seq_source.sv
// avalon_st_seq_source
//   Avalon-ST source that emits one packet of an arithmetic sequence per
//   start request: beat k carries (START_VAL + k*STEP) mod 2^DATA_W, for
//   k = 0 .. COUNT-1. The first beat is marked with sop and the last with eop.
//   The sink's readyLatency (0 or 1) is selected by READY_LATENCY.
//
// Ports
//   clk     : single clock, rising edge
//   resetn  : asynchronous reset, active HIGH (1 = reset) despite the name
//   start   : request one packet; only looked at in IDLE or DONE
//   ready   : sink ready
//   valid   : source valid (registered)
//   data    : beat payload (registered, holds its last value when not valid)
//   sop     : startofpacket, only ever high together with valid
//   eop     : endofpacket, only ever high together with valid
//   busy    : high while arming or streaming a packet
//   done    : high once a packet has completed, until the next start/reset
module avalon_st_seq_source #(
  parameter int DATA_W        = 8,
  parameter int START_VAL     = 4,
  parameter int STEP          = 1,
  parameter int COUNT         = 3,
  parameter int READY_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              sop,
  output logic              eop,
  output logic              busy,
  output logic              done
);

  localparam int                 IDX_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(COUNT - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [DATA_W-1:0]  START_D  = DATA_W'(START_VAL);
  localparam logic [DATA_W-1:0]  STEP_D   = DATA_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] cur;
  // Latency-1 only: the last beat has been issued; the next cycle closes
  // the packet so busy stays high while that beat is on the bus.
  logic              last_iss;

  // Sequence values wrap modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state    <= S_IDLE;
      idx      <= '0;
      cur      <= START_D;
      last_iss <= 1'b0;
      valid    <= 1'b0;
      data     <= '0;
      sop      <= 1'b0;
      eop      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          valid <= 1'b0;
          sop   <= 1'b0;
          eop   <= 1'b0;
          if (start) begin
            state    <= S_ARM;
            idx      <= '0;
            cur      <= START_D;
            last_iss <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end

        S_ARM: begin
          state <= S_STREAM;
          // With latency 0 the first beat must already be on the bus in the
          // first STREAM cycle, so it is loaded here.
          if (READY_LATENCY == 0) begin
            valid <= 1'b1;
            data  <= cur;
            sop   <= 1'b1;
            eop   <= (idx == LAST_IDX);
          end
        end

        S_STREAM: begin
          if (READY_LATENCY == 0) begin
            // Beat stays presented (data/sop/eop stable) until accepted.
            if (valid && ready) begin
              if (idx == LAST_IDX) begin
                valid <= 1'b0;
                sop   <= 1'b0;
                eop   <= 1'b0;
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx  <= idx + IDX_ONE;
                cur  <= wrap_add(cur, STEP_D);
                data <= wrap_add(cur, STEP_D);
                sop  <= 1'b0;
                eop  <= ((idx + IDX_ONE) == LAST_IDX);
              end
            end
          end else begin
            if (last_iss) begin
              valid <= 1'b0;
              sop   <= 1'b0;
              eop   <= 1'b0;
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (ready) begin
              // Sink was ready this cycle, so a beat issued now is a transfer.
              valid <= 1'b1;
              data  <= cur;
              sop   <= (idx == '0);
              eop   <= (idx == LAST_IDX);
              cur   <= wrap_add(cur, STEP_D);
              if (idx == LAST_IDX) begin
                last_iss <= 1'b1;
              end else begin
                idx <= idx + IDX_ONE;
              end
            end else begin
              valid <= 1'b0;
              sop   <= 1'b0;
              eop   <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          valid <= 1'b0;
          sop   <= 1'b0;
          eop   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_seq_source.sv
// Testbench for avalon_st_seq_source. Five instances with different
// parameter sets run side by side; a monitor decides transfers from the
// Avalon-ST readyLatency rules and compares every accepted beat with the
// closed-form sequence value.
module tb_avalon_st_seq_source;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] start, ready, valid, sop, eop, busy, done;
  logic [7:0] d0, d1, d3, d4;
  logic [3:0] d2;
  logic [31:0] dat [5];

  int tests  = 0;
  int failed = 0;
  int k [5];

  always #5 clk = ~clk;

  assign dat[0] = {24'd0, d0};
  assign dat[1] = {24'd0, d1};
  assign dat[2] = {28'd0, d2};
  assign dat[3] = {24'd0, d3};
  assign dat[4] = {24'd0, d4};

  avalon_st_seq_source #(.DATA_W(8), .START_VAL(4), .STEP(1), .COUNT(3), .READY_LATENCY(1)) u0 (
    .clk(clk), .resetn(resetn), .start(start[0]), .ready(ready[0]), .valid(valid[0]),
    .data(d0), .sop(sop[0]), .eop(eop[0]), .busy(busy[0]), .done(done[0]));
  avalon_st_seq_source #(.DATA_W(8), .START_VAL(4), .STEP(1), .COUNT(3), .READY_LATENCY(0)) u1 (
    .clk(clk), .resetn(resetn), .start(start[1]), .ready(ready[1]), .valid(valid[1]),
    .data(d1), .sop(sop[1]), .eop(eop[1]), .busy(busy[1]), .done(done[1]));
  avalon_st_seq_source #(.DATA_W(4), .START_VAL(14), .STEP(1), .COUNT(4), .READY_LATENCY(1)) u2 (
    .clk(clk), .resetn(resetn), .start(start[2]), .ready(ready[2]), .valid(valid[2]),
    .data(d2), .sop(sop[2]), .eop(eop[2]), .busy(busy[2]), .done(done[2]));
  avalon_st_seq_source #(.DATA_W(8), .START_VAL(200), .STEP(30), .COUNT(5), .READY_LATENCY(0)) u3 (
    .clk(clk), .resetn(resetn), .start(start[3]), .ready(ready[3]), .valid(valid[3]),
    .data(d3), .sop(sop[3]), .eop(eop[3]), .busy(busy[3]), .done(done[3]));
  avalon_st_seq_source #(.DATA_W(8), .START_VAL(9), .STEP(2), .COUNT(1), .READY_LATENCY(1)) u4 (
    .clk(clk), .resetn(resetn), .start(start[4]), .ready(ready[4]), .valid(valid[4]),
    .data(d4), .sop(sop[4]), .eop(eop[4]), .busy(busy[4]), .done(done[4]));

  function automatic int cnt_of(input int i);
    case (i)
      0, 1:    return 3;
      2:       return 4;
      3:       return 5;
      default: return 1;
    endcase
  endfunction

  function automatic int rl_of(input int i);
    return (i == 1 || i == 3) ? 0 : 1;
  endfunction

  function automatic int exp_beat(input int i, input int n);
    case (i)
      0, 1:    return (4 + n) % 256;
      2:       return (14 + n) % 16;
      3:       return (200 + 30 * n) % 256;
      default: return 9;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin : monitor
    logic [4:0]  pv, pr, ps, pe, pb;
    logic [31:0] pd [5];
    logic        xfer;
    pv = '0; pr = '0; ps = '0; pe = '0; pb = '0;
    for (int i = 0; i < 5; i++) begin
      pd[i] = '0;
      k[i]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (resetn !== 1'b0) begin
          k[i] = 0;
        end else begin
          if (busy[i] && !pb[i]) k[i] = 0;  // a new packet is being armed
          if (!valid[i])
            chk($sformatf("sopeop_idle[%0d]", i), {sop[i], eop[i]}, 2'b00);
          if (rl_of(i) == 1 && valid[i])
            chk($sformatf("rl1_valid_wo_ready[%0d]", i), pr[i], 1'b1);
          if (rl_of(i) == 0 && pv[i] && !pr[i])
            chk($sformatf("rl0_hold[%0d]", i), {valid[i], sop[i], eop[i], dat[i]},
                {1'b1, ps[i], pe[i], pd[i]});
          xfer = valid[i] && ((rl_of(i) == 1) ? pr[i] : ready[i]);
          if (xfer) begin
            chk($sformatf("extra_beat[%0d]", i), (k[i] < cnt_of(i)), 1'b1);
            chk($sformatf("beat_data[%0d]", i), dat[i], exp_beat(i, k[i]));
            chk($sformatf("beat_sop[%0d]", i), sop[i], (k[i] == 0));
            chk($sformatf("beat_eop[%0d]", i), eop[i], (k[i] == cnt_of(i) - 1));
            k[i]++;
          end
        end
        pv[i] = valid[i]; pr[i] = ready[i]; ps[i] = sop[i]; pe[i] = eop[i];
        pd[i] = dat[i];   pb[i] = busy[i];
      end
    end
  end

  // mode 0: ready held high; 1: ready toggles every cycle with a stray start
  // mid-stream; 2: random ready with random stray starts to busy instances.
  task automatic run_until_done(input int mode, input int budget, input string tag);
    int c;
    c = 0;
    while (done !== 5'h1f && c < budget) begin
      case (mode)
        0:       begin ready = '1; start = '0; end
        1:       begin ready = ~ready; start = (c == 3) ? busy : 5'h00; end
        default: begin
          ready = 5'($urandom);
          start = 5'($urandom) & busy & (($urandom_range(0, 3) == 0) ? 5'h1f : 5'h00);
        end
      endcase
      tick();
      c++;
    end
    start = '0;
    chk({tag, "_done"}, done, 5'h1f);
    chk({tag, "_busy"}, busy, 5'h00);
    chk({tag, "_valid"}, valid, 5'h00);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_count[%0d]", tag, i), k[i], cnt_of(i));
  endtask

  initial begin : stim
    int c;
    resetn = 1'b1;
    start  = '0;
    ready  = '0;
    repeat (3) tick();
    chk("rst_valid", valid, 5'h00);
    chk("rst_sop", sop, 5'h00);
    chk("rst_eop", eop, 5'h00);
    chk("rst_busy", busy, 5'h00);
    chk("rst_done", done, 5'h00);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_data[%0d]", i), dat[i], 0);
    resetn = 1'b0;
    tick();
    chk("idle_busy", busy, 5'h00);

    // Back-to-back stream with ready held high, latency checked directly.
    ready = '1;
    start = '1;
    tick();
    start = '0;
    chk("arm_busy", busy, 5'h1f);
    chk("arm_valid", valid, 5'h00);
    chk("arm_done", done, 5'h00);
    tick();
    chk("stream1_valid", valid, 5'b01010);
    chk("rl0_first_data", dat[1], 4);
    chk("rl0_first_sop", sop[1], 1'b1);
    chk("rl0_wrap_first", dat[3], 200);
    tick();
    chk("stream2_valid", valid, 5'h1f);
    chk("rl1_first_data", dat[0], 4);
    chk("rl1_first_sop", sop[0], 1'b1);
    chk("rl0_second_data", dat[1], 5);
    chk("wrap_first", dat[2], 14);
    chk("single_beat", {dat[4][7:0], sop[4], eop[4]}, {8'd9, 2'b11});
    run_until_done(0, 60, "ready_high");

    // Restart from DONE with ready toggling and a stray start mid-stream.
    start = '1;
    tick();
    start = '0;
    chk("done_clears", done, 5'h00);
    chk("rearm_busy", busy, 5'h1f);
    run_until_done(1, 80, "toggle");
    ready = '1;
    repeat (3) tick();
    chk("done_sticky", done, 5'h1f);

    // Latency 0: first beat held while the sink stalls.
    ready = '0;
    start = '1;
    tick();
    start = '0;
    tick();
    for (c = 0; c < 3; c++) begin
      chk("rl0_stall_valid", valid[1], 1'b1);
      chk("rl0_stall_data", dat[1], 4);
      chk("rl0_stall_sop", sop[1], 1'b1);
      chk("rl1_stall_novalid", valid[0], 1'b0);
      tick();
    end
    run_until_done(0, 60, "after_stall");

    // Randomised ready patterns.
    for (int p = 0; p < 15; p++) begin
      start = '1;
      tick();
      start = '0;
      run_until_done(2, 400, $sformatf("rand%0d", p));
    end

    // Reset in the middle of a packet, then a clean restart.
    ready = '1;
    start = '1;
    tick();
    start = '0;
    for (c = 0; c < 10; c++) begin
      if (valid[0] && dat[0] == 5) break;
      tick();
    end
    chk("reach_beat1", {valid[0], dat[0]}, {1'b1, 32'd5});
    #2 resetn = 1'b1;
    #1;
    chk("midrst_valid", valid, 5'h00);
    chk("midrst_sop", sop, 5'h00);
    chk("midrst_eop", eop, 5'h00);
    chk("midrst_busy", busy, 5'h00);
    chk("midrst_done", done, 5'h00);
    for (int i = 0; i < 5; i++) chk($sformatf("midrst_data[%0d]", i), dat[i], 0);
    tick();
    resetn = 1'b0;
    tick();
    start = '1;
    tick();
    start = '0;
    tick();
    tick();
    chk("restart_data", dat[0], 4);
    chk("restart_sop", sop[0], 1'b1);
    run_until_done(0, 60, "restart");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
